// File: rtl/breath_pkg.sv
// breath_pkg: shared mode encodings and PWM sizing for the breathing sequencer
package breath_pkg;
  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_ALL      = 2'd1,
    MODE_CHASE    = 2'd2,
    MODE_PINGPONG = 2'd3
  } mode_t;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  localparam int CNT_W      = 6;
  localparam int PWM_PERIOD = 64;
endpackage

// File: rtl/breath_sequencer_if.sv
// breath_sequencer_if: switch inputs and LED outputs of the breathing sequencer
interface breath_sequencer_if #(
  parameter int NUM_CH  = 8,
  parameter int PRESC_W = 4
);
  logic                      enable;
  logic [1:0]                mode;
  logic [PRESC_W-1:0]        speed;
  logic [NUM_CH-1:0]         pulse;
  logic [$clog2(NUM_CH)-1:0] active_ch;
  logic                      cycle_done;
  modport master (output enable, mode, speed, input pulse, active_ch, cycle_done);
  modport slave  (input enable, mode, speed, output pulse, active_ch, cycle_done);
endinterface

// File: rtl/breath_lut.sv
// breath_lut: 64-entry breathing duty table; the upper half mirrors the lower half
module breath_lut
  import breath_pkg::*;
(
  input  logic [CNT_W-1:0] i_index,
  output logic [CNT_W-1:0] o_duty
);
  localparam logic [CNT_W-1:0] HALF [32] = '{
    6'd0,  6'd0,  6'd1,  6'd1,  6'd3,  6'd4,  6'd6,  6'd8,
    6'd10, 6'd12, 6'd15, 6'd18, 6'd21, 6'd24, 6'd27, 6'd30,
    6'd33, 6'd36, 6'd39, 6'd42, 6'd45, 6'd48, 6'd51, 6'd53,
    6'd55, 6'd57, 6'd59, 6'd60, 6'd62, 6'd62, 6'd63, 6'd63
  };
  logic [CNT_W-2:0] w_half_idx;
  // 63-i in the upper half is just the inverted low bits
  assign w_half_idx = i_index[CNT_W-1] ? ~i_index[CNT_W-2:0] : i_index[CNT_W-2:0];
  assign o_duty     = HALF[w_half_idx];
endmodule

// File: rtl/breath_sequencer.sv
// breath_sequencer: multi-channel breathing-LED sequencer sharing one duty table and PWM counter
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int PRESC_W = 4
) (
  input logic sysclk,
  input logic rst_n,
  breath_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PWM_PERIOD - 1);
  localparam logic [AW-1:0]    TOP_CH = AW'(NUM_CH - 1);

  state_t             r_state;
  mode_t              r_mode_q;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_index;
  logic [PRESC_W-1:0] r_presc;
  logic               r_dir_up;
  logic [NUM_CH-1:0]  r_pulse;
  logic [AW-1:0]      r_active_ch;
  logic               r_cycle_done;

  logic [CNT_W-1:0]  w_duty;
  logic [NUM_CH-1:0] w_sel;
  logic [AW-1:0]     w_next_ch;
  mode_t             w_mode_req;
  logic w_period_end, w_step, w_boundary, w_go_up, w_wrap, w_go_run, w_stay;

  breath_lut u_lut (.i_index(r_index), .o_duty(w_duty));

  assign w_mode_req   = mode_t'(bus.mode);
  assign w_period_end = r_count == LAST;
  assign w_step       = w_period_end && (r_presc >= bus.speed);
  assign w_boundary   = w_step && (r_index == LAST);
  assign w_sel        = r_mode_q == MODE_ALL ? '1 : NUM_CH'(1) << r_active_ch;
  assign w_go_run     = bus.enable && (r_state == ST_RUN ? !(w_boundary && w_mode_req == MODE_OFF)
                                                         : w_mode_req != MODE_OFF);
  assign w_stay       = r_state == ST_RUN && w_go_run;

  // Ping-pong turns around at either end; landing on channel 0 closes a sequence
  always_comb begin
    w_go_up   = 1'b1;
    w_wrap    = 1'b1;
    w_next_ch = '0;
    if (r_mode_q == MODE_CHASE) begin
      w_wrap    = r_active_ch == TOP_CH;
      w_next_ch = w_wrap ? '0 : r_active_ch + 1'b1;
    end else if (r_mode_q == MODE_PINGPONG) begin
      w_go_up   = r_dir_up ? r_active_ch != TOP_CH : r_active_ch == '0;
      w_next_ch = w_go_up ? r_active_ch + 1'b1 : r_active_ch - 1'b1;
      w_wrap    = !w_go_up && r_active_ch == AW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode_q     <= MODE_OFF;
      r_count      <= '0;
      r_index      <= '0;
      r_presc      <= '0;
      r_dir_up     <= 1'b1;
      r_pulse      <= '0;
      r_active_ch  <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_go_run ? ST_RUN : ST_IDLE;
      r_cycle_done <= r_state == ST_RUN && bus.enable && w_boundary && w_wrap;
      if (!w_stay) begin
        r_mode_q    <= w_go_run ? w_mode_req : MODE_OFF;
        r_count     <= '0;
        r_index     <= '0;
        r_presc     <= '0;
        r_dir_up    <= 1'b1;
        r_pulse     <= '0;
        r_active_ch <= '0;
      end else begin
        r_count <= r_count + 1'b1;
        r_pulse <= {NUM_CH{r_count < w_duty}} & w_sel;
        if (w_step) begin
          r_presc <= '0;
          r_index <= r_index + 1'b1;
        end else if (w_period_end) begin
          r_presc <= r_presc + 1'b1;
        end
        // Mode requests take effect only here so a fade always completes
        if (w_boundary) begin
          r_mode_q    <= w_mode_req;
          r_active_ch <= w_mode_req == MODE_ALL ? '0 : w_next_ch;
          r_dir_up    <= w_mode_req == MODE_ALL || w_go_up;
        end
      end
    end
  end

  assign bus.pulse      = r_pulse;
  assign bus.active_ch  = r_active_ch;
  assign bus.cycle_done = r_cycle_done;
endmodule

// File: tb/tb_breath_sequencer.sv
// tb_breath_sequencer: scoreboard bench comparing the sequencer with a closed-form timing model
module tb_breath_sequencer;
  import breath_pkg::*;

  typedef struct packed {
    logic [7:0] pulse;
    logic [2:0] ach;
    logic       cd;
  } exp_t;

  localparam int DUTY [64] = '{
    0, 0, 1, 1, 3, 4, 6, 8, 10, 12, 15, 18, 21, 24, 27, 30,
    33, 36, 39, 42, 45, 48, 51, 53, 55, 57, 59, 60, 62, 62, 63, 63,
    63, 63, 62, 62, 60, 59, 57, 55, 53, 51, 48, 45, 42, 39, 36, 33,
    30, 27, 24, 21, 18, 15, 12, 10, 8, 6, 4, 3, 1, 1, 0, 0
  };

  logic sysclk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 sysclk = ~sysclk;

  breath_sequencer_if #(.NUM_CH(8), .PRESC_W(4)) ifa ();
  breath_sequencer_if #(.NUM_CH(8), .PRESC_W(4)) ifb ();

  breath_sequencer #(.NUM_CH(8), .PRESC_W(4)) dut_a (.sysclk(sysclk), .rst_n(rst_n), .bus(ifa));
  breath_sequencer #(.NUM_CH(8), .PRESC_W(4)) dut_b (.sysclk(sysclk), .rst_n(rst_n), .bus(ifb));

  function automatic int ch_of(mode_t m, int breaths);
    int p;
    if (m == MODE_CHASE) return breaths % 8;
    if (m == MODE_PINGPONG) begin
      p = breaths % 14;
      return p < 8 ? p : 14 - p;
    end
    return 0;
  endfunction

  // Expected outputs after the t-th edge following the entry edge; idx_u is the LUT index one cycle earlier
  function automatic exp_t model(mode_t m, int t, int s, int idx_u);
    exp_t e;
    int   breath, per;
    breath  = 4096 * (s + 1);
    per     = m == MODE_ALL ? 1 : m == MODE_CHASE ? 8 : 14;
    e.ach   = 3'(ch_of(m, t / breath));
    e.cd    = t > 0 && t % (breath * per) == 0;
    e.pulse = (t > 0 && (t - 1) % 64 < DUTY[idx_u]) ?
              (m == MODE_ALL ? 8'hFF : 8'(1) << ch_of(m, (t - 1) / breath)) : 8'h00;
    return e;
  endfunction

  task automatic go_idle;
    @(posedge sysclk);
    #1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    ifa.speed  = '0;
    ifb.speed  = '0;
    repeat (2) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset;
    exp_t e, got;
    #12;
    got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
    n_total++;
    if (got !== 12'h0) $display("FAIL reset_a got=%h exp=000", got);
    else n_pass++;
    got = {ifb.pulse, ifb.active_ch, ifb.cycle_done};
    n_total++;
    if (got !== 12'h0) $display("FAIL reset_b got=%h exp=000", got);
    else n_pass++;
    @(negedge sysclk);
    rst_n = 1'b1;
    @(posedge sysclk);
    #1;
    ifa.enable = 1'b1;
    ifa.mode   = MODE_ALL;
    for (int t = 0; t <= 985; t++) begin
      @(posedge sysclk);
      #1;
      qa.push_back(model(MODE_ALL, t, 0, ((t - 1) / 64) % 64));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL pre_reset t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
    @(posedge sysclk);
    #2;
    rst_n = 1'b0;
    #1;
    got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
    n_total++;
    if (got !== 12'h0) $display("FAIL async_reset got=%h exp=000", got);
    else n_pass++;
    @(negedge sysclk);
    rst_n = 1'b1;
    for (int t = 0; t <= 200; t++) begin
      @(posedge sysclk);
      #1;
      qa.push_back(model(MODE_ALL, t, 0, ((t - 1) / 64) % 64));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL restart t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_all;
    exp_t e, got;
    go_idle();
    ifa.enable = 1'b1;
    ifa.mode   = MODE_ALL;
    for (int t = 0; t <= 4100; t++) begin
      @(posedge sysclk);
      #1;
      qa.push_back(model(MODE_ALL, t, 0, ((t - 1) / 64) % 64));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL all t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_sequences;
    exp_t e, got;
    go_idle();
    ifa.enable = 1'b1;
    ifa.mode   = MODE_CHASE;
    ifb.enable = 1'b1;
    ifb.mode   = MODE_PINGPONG;
    for (int t = 0; t <= 57350; t++) begin
      @(posedge sysclk);
      #1;
      qa.push_back(model(MODE_CHASE, t, 0, ((t - 1) / 64) % 64));
      qb.push_back(model(MODE_PINGPONG, t, 0, ((t - 1) / 64) % 64));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL chase t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
      e   = qb.pop_front();
      got = {ifb.pulse, ifb.active_ch, ifb.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL pingpong t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_mode_change;
    exp_t e, got;
    go_idle();
    ifa.enable = 1'b1;
    ifa.mode   = MODE_ALL;
    for (int t = 0; t <= 4300; t++) begin
      @(posedge sysclk);
      #1;
      if (t == 1285) ifa.mode = MODE_OFF;
      qa.push_back(t <= 4096 ? model(MODE_ALL, t, 0, ((t - 1) / 64) % 64) : exp_t'(12'h0));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL mode_off t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
  endtask

  task automatic test_speed_enable;
    exp_t e, got;
    int   u;
    go_idle();
    ifa.enable = 1'b1;
    ifa.mode   = MODE_ALL;
    ifa.speed  = 4'd3;
    for (int t = 0; t <= 1960; t++) begin
      @(posedge sysclk);
      #1;
      if (t == 1174) ifa.speed = 4'd0;
      if (t == 1856) ifa.enable = 1'b0;
      u = t - 1;
      qa.push_back(t > 1856 ? exp_t'(12'h0) :
                   model(MODE_ALL, t, 3, u < 1216 ? (u < 0 ? 0 : u / 256) : u / 64 - 14));
      @(negedge sysclk);
      e   = qa.pop_front();
      got = {ifa.pulse, ifa.active_ch, ifa.cycle_done};
      n_total++;
      if (got !== e) $display("FAIL speed_enable t=%0d got=%h exp=%h", t, got, e);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ifa.enable = 1'b0;
    ifa.mode   = MODE_OFF;
    ifa.speed  = '0;
    ifb.enable = 1'b0;
    ifb.mode   = MODE_OFF;
    ifb.speed  = '0;
    test_reset();
    test_all();
    test_sequences();
    test_mode_change();
    test_speed_enable();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
